// File: rtl/burst_ram.sv
// Burst backing-store RAM: one read or strobed write burst of BURST_BEATS words at a time.
// Optional build macro BURST_RAM_CRITICAL_WORD_FIRST_EN starts read bursts at the addressed word.
module burst_ram #(
   parameter int ADDRESS_BITWIDTH = 16,
   parameter int BURST_BEATS      = 8,
   parameter int READ_LATENCY     = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [ADDRESS_BITWIDTH-1:0] cmd_address,
   input  logic [31:0]                 wr_data,
   input  logic [3:0]                  wr_strb,
   input  logic                        wr_data_valid,
   output logic                        wr_data_ready,
   output logic [31:0]                 rd_data,
   output logic                        rd_data_valid
);

   localparam int IDX_W  = $clog2(BURST_BEATS);
   localparam int BASE_W = ADDRESS_BITWIDTH - IDX_W;
   localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_BEATS - 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_t;

   state_t              state_q, state_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [IDX_W-1:0]    beat_q, beat_d;
   logic [IDX_W-1:0]    start_q, start_d;
   logic [BASE_W-1:0]   base_q, base_d;
   logic                wr_en;
   logic [IDX_W-1:0]    word_idx;
   logic [ADDRESS_BITWIDTH-1:0] word_addr;
   logic [IDX_W-1:0]    rd_start;

   logic [31:0] mem [0:(2**ADDRESS_BITWIDTH)-1];

`ifdef BURST_RAM_CRITICAL_WORD_FIRST_EN
   assign rd_start = cmd_address[IDX_W-1:0];
`else
   logic unused_low_bits;
   assign unused_low_bits = ^cmd_address[IDX_W-1:0];
   assign rd_start        = '0;
`endif

   // Index arithmetic is IDX_W wide so the beat wraps within the line.
   assign word_idx  = beat_q + start_q;
   assign word_addr = {base_q, word_idx};

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      lat_d   = lat_q;
      beat_d  = beat_q;
      start_d = start_q;
      base_d  = base_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               base_d = cmd_address[ADDRESS_BITWIDTH-1:IDX_W];
               beat_d = '0;
               if (cmd_write) begin
                  start_d = '0;
                  state_d = WR_BURST;
               end else begin
                  start_d = rd_start;
                  lat_d   = LAT_W'(READ_LATENCY - 1);
                  state_d = (READ_LATENCY == 1) ? RD_BURST : RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            // The read register lags the state by one edge, so leave as the count hits zero.
            lat_d = lat_q - LAT_W'(1);
            if (lat_q == LAT_W'(1)) state_d = RD_BURST;
         end
         RD_BURST: begin
            beat_d = beat_q + IDX_W'(1);
            if (beat_q == LAST_BEAT) state_d = IDLE;
         end
         WR_BURST: begin
            if (wr_data_valid && wr_data_ready) begin
               wr_en  = 1'b1;
               beat_d = beat_q + IDX_W'(1);
               if (beat_q == LAST_BEAT) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state_q       <= IDLE;
         lat_q         <= '0;
         beat_q        <= '0;
         start_q       <= '0;
         base_q        <= '0;
         cmd_ready     <= 1'b1;
         wr_data_ready <= 1'b0;
         rd_data_valid <= 1'b0;
         rd_data       <= '0;
      end else begin
         state_q       <= state_d;
         lat_q         <= lat_d;
         beat_q        <= beat_d;
         start_q       <= start_d;
         base_q        <= base_d;
         // Stay busy one extra cycle after a read so the last beat drains before re-accept.
         cmd_ready     <= (state_d == IDLE) && (state_q != RD_BURST);
         wr_data_ready <= (state_d == WR_BURST);
         rd_data_valid <= (state_q == RD_BURST);
         if (state_q == RD_BURST) rd_data <= mem[word_addr];
      end
   end

   // NOTE: the storage array has no reset; contents survive rst_n and start undefined.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) mem[word_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_burst_ram.sv
// Directed self-checking bench for burst_ram (default parameters, either macro build).
module tb_burst_ram;

   localparam int L = 4;
   localparam int B = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [15:0] cmd_address = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_strb = '0;
   logic        wr_data_valid = 1'b0;
   logic        wr_data_ready;
   logic [31:0] rd_data;
   logic        rd_data_valid;

   int n_cmp = 0;
   int n_err = 0;

   // Results gathered by the stimulus tasks, compared by the test tasks.
   int          acc_wait;
   int          wr_cycles;
   bit          ready_early;
   logic [31:0] wr_vec [B];
   logic [3:0]  strb_vec [B];
   logic [31:0] rd_beats [B];
   int          n_valid, first_cyc, last_cyc;
   logic        ready_last, ready_after;
   logic [31:0] hold_data;
   logic [31:0] exp_line [B];

   burst_ram dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_data_valid(wr_data_valid),
      .wr_data_ready(wr_data_ready),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid)
   );

   always #5 clk = ~clk;

   task automatic issue_cmd(input logic wr, input logic [15:0] addr);
      logic rdy;
      cmd_valid   = 1'b1;
      cmd_write   = wr;
      cmd_address = addr;
      acc_wait    = 0;
      while (1) begin
         rdy = cmd_ready;
         @(posedge clk); #1;
         acc_wait++;
         if (rdy) break;
         if (acc_wait >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_accept_timeout: waited %0d cycles, required acceptance", acc_wait);
            break;
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic write_burst(input logic [15:0] addr, input int stall);
      int  k = 0;
      int  stall_rem = stall;
      logic rdy, vld;
      issue_cmd(1'b1, addr);
      wr_cycles   = 0;
      ready_early = 1'b0;
      while (k < B && wr_cycles < 100) begin
         if (k == 4 && stall_rem > 0) begin
            vld = 1'b0;
            stall_rem--;
         end else begin
            vld = 1'b1;
         end
         wr_data_valid = vld;
         wr_data       = wr_vec[k];
         wr_strb       = strb_vec[k];
         rdy           = wr_data_ready;
         @(posedge clk); #1;
         wr_cycles++;
         if (rdy && vld) k++;
         if (k < B && cmd_ready) ready_early = 1'b1;
      end
      wr_data_valid = 1'b0;
      if (k < B) begin
         n_cmp++; n_err++;
         $display("FAIL write_timeout: %0d beats accepted, required %0d", k, B);
      end
   endtask

   task automatic read_burst(input logic [15:0] addr);
      issue_cmd(1'b0, addr);
      n_valid = 0; first_cyc = -1; last_cyc = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (rd_data_valid) begin
            if (n_valid < B) rd_beats[n_valid] = rd_data;
            if (n_valid == 0) first_cyc = c;
            last_cyc = c;
            n_valid++;
         end
         if (c == L + B - 1) ready_last = cmd_ready;
         if (c == L + B) begin
            ready_after = cmd_ready;
            hold_data   = rd_data;
         end
      end
   endtask

   task automatic compare_read(input string tag, input int start);
      n_cmp++;
      if (n_valid !== B || first_cyc !== L || last_cyc !== L + B - 1) begin
         n_err++;
         $display("FAIL %s_timing: beats=%0d first=%0d last=%0d, required %0d/%0d/%0d",
                  tag, n_valid, first_cyc, last_cyc, B, L, L + B - 1);
      end
      for (int k = 0; k < B; k++) begin
         n_cmp++;
         if (rd_beats[k] !== exp_line[(start + k) % B]) begin
            n_err++;
            $display("FAIL %s_beat%0d: got %h, required %h", tag, k, rd_beats[k],
                     exp_line[(start + k) % B]);
         end
      end
   endtask

   task automatic test_reset();
      #23;
      n_cmp++;
      if (cmd_ready !== 1'b1 || wr_data_ready !== 1'b0 || rd_data_valid !== 1'b0 || rd_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: cmd_ready=%b wr_data_ready=%b rd_data_valid=%b rd_data=%h, required 1/0/0/0",
                  cmd_ready, wr_data_ready, rd_data_valid, rd_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < B; k++) begin
         wr_vec[k]   = 32'hCAFE_0000 + k;
         strb_vec[k] = 4'hF;
      end
      write_burst(16'h0020, 0);
      n_cmp++;
      if (acc_wait !== 1) begin
         n_err++;
         $display("FAIL reset_first_accept: accepted after %0d edges, required 1", acc_wait);
      end
   endtask

   task automatic test_write_read();
      for (int k = 0; k < B; k++) begin
         wr_vec[k]   = 32'h1234_5678 + k;
         strb_vec[k] = 4'hF;
         exp_line[k] = 32'h1234_5678 + k;
      end
      write_burst(16'h0010, 0);
      n_cmp++;
      if (wr_cycles !== B || ready_early !== 1'b0) begin
         n_err++;
         $display("FAIL wr_b2b_cycles: cycles=%0d early_ready=%b, required %0d/0", wr_cycles, ready_early, B);
      end
      n_cmp++;
      if (cmd_ready !== 1'b1 || wr_data_ready !== 1'b0) begin
         n_err++;
         $display("FAIL wr_done_flags: cmd_ready=%b wr_data_ready=%b, required 1/0", cmd_ready, wr_data_ready);
      end
      read_burst(16'h0010);
      compare_read("rd_full", 0);
      n_cmp++;
      if (ready_last !== 1'b0 || ready_after !== 1'b1) begin
         n_err++;
         $display("FAIL rd_cmd_ready: at_last=%b after=%b, required 0/1", ready_last, ready_after);
      end
      n_cmp++;
      if (hold_data !== 32'h1234_567F) begin
         n_err++;
         $display("FAIL rd_hold: got %h, required 1234567f", hold_data);
      end
   endtask

   task automatic test_partial_write();
      for (int k = 0; k < B; k++) begin
         wr_vec[k]   = 32'hFFFF_FFFF;
         strb_vec[k] = 4'h0;
      end
      wr_vec[0] = 32'hAAAA_BBBB; strb_vec[0] = 4'b0011;
      wr_vec[1] = 32'hDDDD_EEEE; strb_vec[1] = 4'b1100;
      exp_line[0] = 32'h1234_BBBB;
      exp_line[1] = 32'hDDDD_5679;
      write_burst(16'h0010, 0);
      read_burst(16'h0010);
      compare_read("rd_partial", 0);
   endtask

   task automatic test_write_stall();
      logic [31:0] saved [B];
      for (int k = 0; k < B; k++) saved[k] = exp_line[k];
      for (int k = 0; k < B; k++) begin
         wr_vec[k]   = 32'h5000_0000 + k * 32'h11;
         strb_vec[k] = 4'hF;
         exp_line[k] = 32'h5000_0000 + k * 32'h11;
      end
      write_burst(16'h0030, 3);
      n_cmp++;
      if (wr_cycles !== B + 3 || ready_early !== 1'b0 || cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL wr_stall: cycles=%0d early_ready=%b cmd_ready=%b, required %0d/0/1",
                  wr_cycles, ready_early, cmd_ready, B + 3);
      end
      read_burst(16'h0030);
      compare_read("rd_stall", 0);
      for (int k = 0; k < B; k++) exp_line[k] = saved[k];
   endtask

   task automatic test_busy_cmd_read();
      int start;
`ifdef BURST_RAM_CRITICAL_WORD_FIRST_EN
      start = 3;
`else
      start = 0;
`endif
      issue_cmd(1'b0, 16'h0030);
      read_burst(16'h0013);
      n_cmp++;
      if (acc_wait !== L + B + 1) begin
         n_err++;
         $display("FAIL busy_accept: accepted after %0d edges, required %0d", acc_wait, L + B + 1);
      end
      compare_read("rd_busy13", start);
   endtask

   task automatic test_reset_mid_read();
      issue_cmd(1'b0, 16'h0030);
      for (int c = 1; c <= L + 3; c++) begin
         @(posedge clk); #1;
      end
      n_cmp++;
      if (rd_data_valid !== 1'b1 || rd_data !== 32'h5000_0033) begin
         n_err++;
         $display("FAIL mid_beat3: valid=%b data=%h, required 1/50000033", rd_data_valid, rd_data);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rd_data_valid !== 1'b0 || cmd_ready !== 1'b1 || wr_data_ready !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: valid=%b cmd_ready=%b wr_data_ready=%b, required 0/1/0",
                  rd_data_valid, cmd_ready, wr_data_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_ready: cmd_ready=%b, required 1", cmd_ready);
      end
      read_burst(16'h0010);
      compare_read("rd_after_rst", 0);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_partial_write();
      test_write_stall();
      test_busy_cmd_read();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
